// File: rtl/rr_stream_mux.sv
// N-channel registered stream mux with fixed-address or round-robin selection.
// Optional out_parity port is enabled by defining RR_STREAM_MUX_PARITY_EN.
module rr_stream_mux #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned SELW = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mode,
   input  logic [SELW-1:0]      addr,
   input  logic [NCH*W-1:0]     in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [W-1:0]         out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
`ifdef RR_STREAM_MUX_PARITY_EN
   ,output logic                out_parity
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_sel_q, out_sel_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic            out_parity_q, out_parity_d;

   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic [W-1:0]    gnt_word;
   logic            accept;
   logic            xfer;

   // Grant: addressed channel, or first valid channel at/after ptr with wraparound
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (!mode) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (addr == SELW'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (!gnt_vld && in_valid[i] && SELW'(i) >= ptr_q) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
         for (int unsigned i = 0; i < NCH; i++) begin
            if (!gnt_vld && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_word = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (gnt_idx == SELW'(i)) gnt_word = in_data[i*W +: W];
      end
   end

   // Reset blocks any handshake so no producer sees a word accepted and then dropped
   assign accept = !reset && ((state_q == EMPTY) || out_ready);
   assign xfer   = accept && gnt_vld;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         out_data_q   <= '0;
         out_sel_q    <= '0;
         ptr_q        <= '0;
         out_parity_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         out_data_q   <= out_data_d;
         out_sel_q    <= out_sel_d;
         ptr_q        <= ptr_d;
         out_parity_q <= out_parity_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (xfer) state_d = FULL;
         FULL:    if (!xfer && out_ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready     = '0;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      out_parity_d = out_parity_q;
      ptr_d        = ptr_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         in_ready[i] = xfer && (gnt_idx == SELW'(i));
      end
      if (xfer) begin
         out_data_d   = gnt_word;
         out_sel_d    = gnt_idx;
         out_parity_d = ^gnt_word;
         if (mode) begin
            ptr_d = (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + SELW'(1);
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = (state_q == FULL);

`ifdef RR_STREAM_MUX_PARITY_EN
   assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed vector table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_rr_stream_mux;
   localparam int unsigned NCH  = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned SELW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              mode;
   logic [SELW-1:0]   addr;
   logic [NCH*W-1:0]  in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [W-1:0]      out_data;
   logic              out_valid;
   logic              out_ready;
   logic [SELW-1:0]   out_sel;
`ifdef RR_STREAM_MUX_PARITY_EN
   logic              out_parity;
`endif

   int errors = 0;
   int checks = 0;

   rr_stream_mux #(.NCH(NCH), .W(W), .SELW(SELW)) dut (
      .clk(clk), .reset(reset), .mode(mode), .addr(addr),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel)
`ifdef RR_STREAM_MUX_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        mode;
      logic [1:0]  addr;
      logic [3:0]  vld;
      logic        ordy;
      logic [31:0] data;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_od;
      logic [1:0]  e_os;
   } vec_t;

   vec_t vt[$];

   // Behavioural reference state
   logic       m_v;
   logic [7:0] m_d;
   int         m_s;
   int         m_ptr;
   logic       m_p;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic md, input logic [1:0] ad,
                               input logic [3:0] vl, input logic ordy, input logic [31:0] dt,
                               input logic [3:0] erdy, input logic eov, input logic [7:0] eod,
                               input logic [1:0] eos);
      vec_t v;
      v.rst = rst; v.mode = md; v.addr = ad; v.vld = vl; v.ordy = ordy; v.data = dt;
      v.e_rdy = erdy; v.e_ov = eov; v.e_od = eod; v.e_os = eos;
      return v;
   endfunction

   // Model grant: modular search from the pointer, or the addressed channel
   function automatic int mgrant(input logic md, input logic [1:0] ad, input logic [3:0] vl);
      if (!md) begin
         if (int'(ad) < NCH && vl[ad]) return int'(ad);
         return -1;
      end
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (vl[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic rst, input logic md, input logic [1:0] ad,
                        input logic [3:0] vl, input logic ordy, input logic [31:0] dt);
      reset = rst; mode = md; addr = ad; in_valid = vl; out_ready = ordy; in_data = dt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] D_INC = 32'h13121110;

   initial begin
      int g;
      logic acc;
      logic [3:0] erdy;

      // Reset, fixed select, rr fairness, backpressure, mid-op reset, mode switch
      vt.push_back(mk(1, 1, 0, 4'b1111, 1, D_INC,        4'b0000, 0, 8'h00, 0));
      vt.push_back(mk(1, 1, 0, 4'b1111, 1, D_INC,        4'b0000, 0, 8'h00, 0));
      vt.push_back(mk(0, 1, 0, 4'b1111, 0, D_INC,        4'b0001, 1, 8'h10, 0));
      vt.push_back(mk(0, 0, 2, 4'b1111, 1, 32'h13A51110, 4'b0100, 1, 8'hA5, 2));
      vt.push_back(mk(0, 0, 3, 4'b0111, 1, D_INC,        4'b0000, 0, 8'hA5, 2));
      vt.push_back(mk(1, 1, 0, 4'b1111, 1, D_INC,        4'b0000, 0, 8'h00, 0));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 1, 0, 4'b1111, 1, D_INC, 4'(1 << (i % 4)), 1,
                         8'(8'h10 + i % 4), 2'(i % 4)));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk(0, 1, 0, 4'b1010, 1, D_INC, (i % 2 == 0) ? 4'b0010 : 4'b1000, 1,
                         (i % 2 == 0) ? 8'h11 : 8'h13, (i % 2 == 0) ? 2'd1 : 2'd3));
      vt.push_back(mk(0, 0, 0, 4'b0001, 1, 32'h1312113C, 4'b0001, 1, 8'h3C, 0));
      for (int i = 0; i < 3; i++)
         vt.push_back(mk(0, 1, 0, 4'b0010, 0, D_INC, 4'b0000, 1, 8'h3C, 0));
      vt.push_back(mk(0, 1, 0, 4'b0010, 1, D_INC,        4'b0010, 1, 8'h11, 1));
      vt.push_back(mk(0, 1, 0, 4'b0100, 0, D_INC,        4'b0000, 1, 8'h11, 1));
      vt.push_back(mk(1, 1, 0, 4'b1111, 0, D_INC,        4'b0000, 0, 8'h00, 0));
      vt.push_back(mk(0, 1, 0, 4'b1110, 1, D_INC,        4'b0010, 1, 8'h11, 1));
      vt.push_back(mk(0, 1, 0, 4'b0100, 1, D_INC,        4'b0100, 1, 8'h12, 2));
      vt.push_back(mk(0, 0, 0, 4'b1111, 1, D_INC,        4'b0001, 1, 8'h10, 0));
      vt.push_back(mk(0, 1, 0, 4'b1111, 1, D_INC,        4'b1000, 1, 8'h13, 3));
      vt.push_back(mk(0, 1, 0, 4'b0000, 1, D_INC,        4'b0000, 0, 8'h13, 3));

      foreach (vt[i]) begin
         drive(vt[i].rst, vt[i].mode, vt[i].addr, vt[i].vld, vt[i].ordy, vt[i].data);
         #1;
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
         tick();
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
         check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vt[i].e_od));
         check($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(vt[i].e_os));
      end

      // Held word survives mode/addr churn under backpressure; ptr untouched by mode 0
      drive(0, 0, 2, 4'b1111, 1, 32'h135A1110);
      #1;
      check("hold load in_ready", 32'(in_ready), 32'h4);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'($urandom), 2'($urandom), 4'b1111, 0, $urandom);
         #1;
         check("hold in_ready", 32'(in_ready), 32'h0);
         tick();
         check("hold out_data", 32'(out_data), 32'h5A);
         check("hold out_sel", 32'(out_sel), 32'h2);
         check("hold out_valid", 32'(out_valid), 32'h1);
      end
      drive(0, 1, 0, 4'b1111, 1, D_INC);
      #1;
      check("release in_ready", 32'(in_ready), 32'h1);
      tick();
      check("release out_data", 32'(out_data), 32'h10);

`ifdef RR_STREAM_MUX_PARITY_EN
      drive(0, 0, 1, 4'b1111, 1, 32'h13120710);
      tick();
      check("parity 07 data", 32'(out_data), 32'h07);
      check("parity 07", 32'(out_parity), 32'h1);
      drive(0, 0, 1, 4'b1111, 1, 32'h13120310);
      tick();
      check("parity 03", 32'(out_parity), 32'h0);
`endif

      // Randomized traffic against the model, starting from a reset
      m_v = 0; m_d = '0; m_s = 0; m_ptr = 0; m_p = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         drive((cyc == 0) || ($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom),
               4'($urandom), $urandom_range(0, 3) != 0, $urandom);
         #1;
         g    = mgrant(mode, addr, in_valid);
         acc  = !reset && (!m_v || out_ready);
         erdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
         if (cyc > 0) check("rand in_ready", 32'(in_ready), 32'(erdy));
         @(posedge clk);
         if (reset) begin
            m_v = 0; m_d = '0; m_s = 0; m_ptr = 0; m_p = 0;
         end else if (acc && g >= 0) begin
            m_v = 1;
            m_d = in_data[g*W +: W];
            m_s = g;
            m_p = ^in_data[g*W +: W];
            if (mode) m_ptr = (g + 1) % NCH;
         end else if (m_v && out_ready) begin
            m_v = 0;
         end
         #1;
         check("rand out_valid", 32'(out_valid), 32'(m_v));
         check("rand out_data", 32'(out_data), 32'(m_d));
         check("rand out_sel", 32'(out_sel), 32'(m_s));
`ifdef RR_STREAM_MUX_PARITY_EN
         check("rand out_parity", 32'(out_parity), 32'(m_p));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
Parametrised N-channel, W-bit registered stream multiplexer. It is the clocked, handshaked successor to the combinational 4:1 single-bit multiplexer.
Two selection modes:
- fixed address select, where addr picks the channel;
- round-robin arbitration across all valid channels.
It sits between several producer streams and a single consumer, with a one-entry output register and valid/ready flow control on both sides.

Parameters:
NCH, 4, number of input channels (2..16)
W, 8, data width per channel in bits
SELW, 2, select/pointer width; 2**SELW >= NCH is required

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via addr, 1 = round-robin
addr  input  SELW  channel select, used only when mode=0
in_data  input  NCH*W  channel i occupies bits [i*W+W-1 : i*W]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready; at most one bit high in any cycle
out_data  output  W  registered output word
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_sel  output  SELW  channel index that supplied out_data

Behaviour:
- Reset: one clock with reset=1 sets out_valid=0, out_data=0, out_sel=0 and rr pointer ptr=0. Any held word is dropped. Reset takes priority over every other event in that cycle.
- States:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - accept = !out_valid || out_ready, so a drain and a load may occur in the same cycle.
- Grant, combinational from the current inputs:
  - mode=0: candidate = addr. If addr >= NCH, there is no candidate and no grant. If in_valid[addr]=0, there is no grant.
  - mode=1: grant = first i with in_valid[i]=1, searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (modulo NCH). If no in_valid bit is set, there is no grant.
- in_ready[i] = accept && (grant == i). All other in_ready bits are 0. in_ready never depends on in_valid of a non-granted channel.
- Transfer occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= channel g word;
  - out_sel <= g;
  - out_valid <= 1.
- No transfer but out_valid && out_ready: out_valid <= 0. out_data and out_sel hold their last values.
- Latency: 1 cycle from input transfer to out_valid=1. Throughput: 1 word/cycle when out_ready is held at 1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid are stable and every in_ready bit is 0.
- Round-robin pointer:
  - After a transfer in mode=1, ptr <= (g+1) modulo NCH, wrapping NCH-1 -> 0.
  - In mode=0 transfers, ptr is unchanged.
  - ptr is not cleared by a mode change.
- Mode or addr changes while FULL do not alter the held word. The new selection applies to the next load.
- Channels not granted keep their valid asserted. No data is lost or duplicated; each accepted word appears on the output exactly once.

Optional Feature:
RR_STREAM_MUX_PARITY_EN
- Defined:
  - An extra output port out_parity (1 bit) is present. It is registered with out_data and equals the XOR reduction of the loaded word.
  - out_parity is reset to 0 and held under backpressure under the same rules as out_data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. First release cycle in mode=1 grants ch0.
2. Fixed select: mode=0, addr=2, in_valid=1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_sel=2. Then addr=3 with in_valid[3]=0 -> in_ready=0000 and out_valid falls to 0.
3. Round-robin fairness: mode=1, in_valid=1111, out_ready=1, channel i data = 8'h10+i, for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data. Then in_valid=1010 -> sequence 1,3,1,3.
4. Backpressure: FULL with out_data=8'h3C, drop out_ready for 3 cycles -> out_data=3C, out_valid=1, in_ready=0000 throughout. Raise out_ready with a pending ch1 -> ch1 word loads on the same edge as the drain.
5. Reset mid-operation: FULL with pending grants, assert reset for 1 cycle -> out_valid=0, ptr=0, held word never seen on the output. Next grant in mode=1 goes to the lowest valid channel.
6. Mode switch and parity (with RR_STREAM_MUX_PARITY_EN defined):
   - mode=1 grant ch2, switch to mode=0 addr=0, then back to mode=1 -> next rr grant searches from ch3.
   - Load word 8'h07 -> out_parity=1.
